jk_reg_bank: RTL

//   Parametrised bank of WIDTH JK flip-flops sharing one clock, with synchronous reset.

---
 rtl/jk_reg_bank.sv | 104 ++++++++++
 1 files changed

// File: rtl/jk_reg_bank.sv
// ----------------------------------------------------------------------------
// jk_reg_bank
//   Bank of WIDTH JK flip-flops on one clock. It adds a clock enable, a
//   parallel load, registered per-bit change flags and a saturating count of
//   toggle operations. It serves as a general control/status register bank.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-high (highest priority)
//   en          enable for the JK update
//   j, k        per-bit J and K inputs
//   load        parallel load strobe; overrides en/j/k
//   load_data   value written by load
//   cnt_clr     synchronous clear of toggle_cnt; wins over same-cycle toggles
//   q           flip-flop state
//   q_n         ~q, combinational
//   changed     bit i is set when q[i] changed on the previous edge
//   toggle_cnt  saturating count of JK toggle (j=k=1) operations
// ----------------------------------------------------------------------------
module jk_reg_bank #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] changed,
    output logic [CNT_W-1:0] toggle_cnt
);

    // Popcount width, and a sum width one bit wider than either operand so
    // the addition can never wrap before the saturation compare.
    localparam int PW = $clog2(WIDTH + 1);
    localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] q_next;
    logic [PW-1:0]    pop;
    logic [SW-1:0]    sum;
    logic [CNT_W-1:0] cnt_next;
    logic             jk_active;

    assign jk_active = en && !load;

    always_comb begin
        q_next = q;
        if (load) begin
            q_next = load_data;
        end else if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({j[i], k[i]})
                    2'b01:   q_next[i] = 1'b0;
                    2'b10:   q_next[i] = 1'b1;
                    2'b11:   q_next[i] = ~q[i];
                    default: q_next[i] = q[i];
                endcase
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + PW'(j[i] & k[i]);
        end
    end

    always_comb begin
        sum      = SW'(toggle_cnt) + SW'(pop);
        cnt_next = toggle_cnt;
        if (cnt_clr) begin
            cnt_next = '0;
        end else if (jk_active) begin
            if (sum > SW'(CNT_MAX)) begin
                cnt_next = CNT_MAX;
            end else begin
                cnt_next = CNT_W'(sum);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q          <= RST_VAL;
            changed    <= '0;
            toggle_cnt <= '0;
        end else begin
            q          <= q_next;
            changed    <= q_next ^ q;
            toggle_cnt <= cnt_next;
        end
    end

    assign q_n = ~q;

endmodule
